// File: rtl/alu_issue_if.sv
// Handshake and data bundle between the ALU issue stage and its neighbours.
// The stage itself connects through the slave modport.
interface alu_issue_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_insn;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;
    logic            out_valid;
    logic            out_ready;
    logic            out_insn30;
    logic [2:0]      out_funct3;
    logic            out_w;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_insn, in_pc, in_rs1_val, in_rs2_val,
               wb_valid, wb_rd, wb_result, out_ready,
        input  in_ready, out_valid, out_insn30, out_funct3, out_w,
               out_op1, out_op2, out_rd, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_insn, in_pc, in_rs1_val, in_rs2_val,
               wb_valid, wb_rd, wb_result, out_ready,
        output in_ready, out_valid, out_insn30, out_funct3, out_w,
               out_op1, out_op2, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV64I/RV32I integer issue stage: decode, operand select, writeback bypass,
// and a registered output with a one-entry skid buffer.
module alu_issue #(
    parameter int XLEN = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    alu_issue_if.slave  bus
);
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    typedef struct packed {
        logic            insn30;
        logic [2:0]      funct3;
        logic            w;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    logic [31:0]     insn;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [4:0]      rs_idx [2];
    logic [XLEN-1:0] rf_val [2];
    logic [XLEN-1:0] rsv    [2];

    assign insn      = bus.in_insn;
    assign f3        = insn[14:12];
    assign f7        = insn[31:25];
    assign imm_i     = XLEN'($signed(insn[31:20]));
    assign imm_u     = XLEN'($signed({insn[31:12], 12'h000}));
    assign rs_idx[0] = insn[19:15];
    assign rs_idx[1] = insn[24:20];
    assign rf_val[0] = bus.in_rs1_val;
    assign rf_val[1] = bus.in_rs2_val;

    // x0 is never forwarded: a writeback to x0 carries no architectural value.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            assign rsv[gi] = (bus.wb_valid && bus.wb_rd == rs_idx[gi] && bus.wb_rd != 5'd0)
                           ? bus.wb_result : rf_val[gi];
        end
    endgenerate

    logic   legal;
    logic   f3_slt;
    logic   f3_add_sr;
    entry_t raw;
    entry_t dec;

    always_comb begin
        legal      = 1'b0;
        f3_slt     = (f3 == 3'd2) || (f3 == 3'd3);
        f3_add_sr  = (f3 == 3'd0) || (f3 == 3'd5);
        raw        = '0;
        raw.rd     = insn[11:7];
        raw.funct3 = f3;
        case (insn[6:0])
            OPC_OP: begin
                raw.op1    = rsv[0];
                raw.op2    = rsv[1];
                raw.insn30 = f3_slt || (f3_add_sr && insn[30]);
                legal      = (f7 == 7'd0) || (f7 == 7'b0100000 && f3_add_sr);
            end
            OPC_OP_IMM: begin
                raw.op1    = rsv[0];
                raw.op2    = imm_i;
                raw.insn30 = f3_slt || (f3 == 3'd5 && insn[30]);
                if (f3 == 3'd1)
                    legal = (insn[31:26] == 6'b000000);
                else if (f3 == 3'd5)
                    legal = (insn[31:26] == 6'b000000) || (insn[31:26] == 6'b010000);
                else
                    legal = 1'b1;
            end
            OPC_OP_32: begin
                raw.op1    = rsv[0];
                raw.op2    = rsv[1];
                raw.w      = 1'b1;
                raw.insn30 = f3_add_sr && insn[30];
                legal      = (XLEN == 64) && (f3_add_sr || f3 == 3'd1)
                          && ((f7 == 7'd0) || (f7 == 7'b0100000 && f3_add_sr));
            end
            OPC_OP_IMM_32: begin
                raw.op1    = rsv[0];
                raw.op2    = imm_i;
                raw.w      = 1'b1;
                raw.insn30 = (f3 == 3'd5) && insn[30];
                legal      = (XLEN == 64)
                          && ((f3 == 3'd0) || ((f3 == 3'd1 || f3 == 3'd5) && !insn[25]));
            end
            OPC_LUI: begin
                raw.op2    = imm_u;
                raw.funct3 = 3'd0;
                legal      = 1'b1;
            end
            OPC_AUIPC: begin
                raw.op1    = bus.in_pc;
                raw.op2    = imm_u;
                raw.funct3 = 3'd0;
                legal      = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        dec = raw;
        if (!legal) begin
            dec         = '0;
            dec.rd      = insn[11:7];
            dec.illegal = 1'b1;
        end
    end

    entry_t out_reg;
    entry_t skid_reg;
    logic   out_valid_reg;
    logic   skid_valid_reg;
    logic   accept;

    assign accept = bus.in_valid && !skid_valid_reg;

    // The output slot refills whenever it is empty or being drained; otherwise
    // a new arrival parks in the skid slot and in_ready drops next cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (bus.flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!out_valid_reg || bus.out_ready) begin
            if (skid_valid_reg) begin
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= accept;
                if (accept)
                    out_reg <= dec;
            end
        end else if (accept) begin
            skid_reg       <= dec;
            skid_valid_reg <= 1'b1;
        end
    end

    assign bus.in_ready    = !skid_valid_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_insn30  = out_reg.insn30;
    assign bus.out_funct3  = out_reg.funct3;
    assign bus.out_w       = out_reg.w;
    assign bus.out_op1     = out_reg.op1;
    assign bus.out_op2     = out_reg.op2;
    assign bus.out_rd      = out_reg.rd;
    assign bus.out_illegal = out_reg.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Randomized and directed bench for alu_issue against a queue-based reference model.
module tb_alu_issue;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    alu_issue_if #(.XLEN(XLEN)) bus ();

    alu_issue #(.XLEN(XLEN)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    bit check_en = 1'b0;

    typedef struct {
        logic        insn30;
        logic [2:0]  funct3;
        logic        w;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] insn, input logic [63:0] pc,
                                        input logic [63:0] rs1, input logic [63:0] rs2,
                                        input logic wbv, input logic [4:0] wbrd,
                                        input logic [63:0] wbres);
        exp_t e;
        logic [63:0] a, b, immi, immu;
        logic ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3   = insn[14:12];
        f7   = insn[31:25];
        immi = {{52{insn[31]}}, insn[31:20]};
        immu = {{32{insn[31]}}, insn[31:12], 12'h000};
        a = (wbv && wbrd != 5'd0 && wbrd == insn[19:15]) ? wbres : rs1;
        b = (wbv && wbrd != 5'd0 && wbrd == insn[24:20]) ? wbres : rs2;
        e = '{default: '0};
        ok = 1'b0;
        case (insn[6:0])
            7'b0110011, 7'b0111011: begin
                e.w = (insn[6:0] == 7'b0111011);
                ok = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
                if (e.w && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ok = 1'b0;
                e.op1 = a; e.op2 = b; e.funct3 = f3;
                if (f3 == 3'd2 || f3 == 3'd3) e.insn30 = 1'b1;
                else if (f3 == 3'd0 || f3 == 3'd5) e.insn30 = insn[30];
            end
            7'b0010011: begin
                if (f3 == 3'd1) ok = (insn[31:26] == 6'b000000);
                else if (f3 == 3'd5) ok = (insn[31:26] == 6'b000000) || (insn[31:26] == 6'b010000);
                else ok = 1'b1;
                e.op1 = a; e.op2 = immi; e.funct3 = f3;
                if (f3 == 3'd2 || f3 == 3'd3) e.insn30 = 1'b1;
                else if (f3 == 3'd5) e.insn30 = insn[30];
            end
            7'b0011011: begin
                ok = (f3 == 3'd0) || ((f3 == 3'd1 || f3 == 3'd5) && !insn[25]);
                e.op1 = a; e.op2 = immi; e.funct3 = f3; e.w = 1'b1;
                if (f3 == 3'd5) e.insn30 = insn[30];
            end
            7'b0110111: begin ok = 1'b1; e.op2 = immu; end
            7'b0010111: begin ok = 1'b1; e.op1 = pc; e.op2 = immu; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '{default: '0};
            e.illegal = 1'b1;
        end
        e.rd = insn[11:7];
        return e;
    endfunction

    // Model: ordered queue of at most two pending entries.
    always @(posedge clk) begin
        exp_t e;
        bit cons, acc;
        if (!reset_n || bus.flush) begin
            q.delete();
        end else begin
            cons = (q.size() > 0) && bus.out_ready;
            acc  = bus.in_valid && (q.size() < 2);
            if (acc)
                e = ref_decode(bus.in_insn, bus.in_pc, bus.in_rs1_val, bus.in_rs2_val,
                               bus.wb_valid, bus.wb_rd, bus.wb_result);
            if (cons) begin
                $display("out #%0d rd=%0d op1=%h op2=%h f3=%0d i30=%0d w=%0d ill=%0d",
                         n_out, q[0].rd, q[0].op1, q[0].op2, q[0].funct3,
                         q[0].insn30, q[0].w, q[0].illegal);
                void'(q.pop_front());
                n_out++;
            end
            if (acc) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            if (q.size() > 0 && bus.out_valid) begin
                chk("insn30", 64'(bus.out_insn30), 64'(q[0].insn30));
                chk("funct3", 64'(bus.out_funct3), 64'(q[0].funct3));
                chk("w", 64'(bus.out_w), 64'(q[0].w));
                chk("op1", bus.out_op1, q[0].op1);
                chk("op2", bus.out_op2, q[0].op2);
                chk("rd", 64'(bus.out_rd), 64'(q[0].rd));
                chk("illegal", 64'(bus.out_illegal), 64'(q[0].illegal));
            end
        end
    end

    task automatic drive(input logic [31:0] insn, input logic [63:0] pc,
                         input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic wbv, input logic [4:0] wbrd, input logic [63:0] wbres);
        bus.in_valid   = 1'b1;
        bus.in_insn    = insn;
        bus.in_pc      = pc;
        bus.in_rs1_val = rs1;
        bus.in_rs2_val = rs2;
        bus.wb_valid   = wbv;
        bus.wb_rd      = wbrd;
        bus.wb_result  = wbres;
    endtask

    task automatic send(input logic [31:0] insn, input logic [63:0] pc,
                        input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic wbv, input logic [4:0] wbrd, input logic [63:0] wbres);
        drive(insn, pc, rs1, rs2, wbv, wbrd, wbres);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b0;
    endtask

    function automatic logic [31:0] addi_rd(input int r);
        logic [31:0] v;
        v = 32'h00100013;
        v[11:7] = 5'(r);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        drive(32'h00138213, 64'h0, 64'h5, 64'h6, 1'b0, 5'd0, 64'h0);

        // Reset held 3 cycles with a valid input offered.
        @(posedge clk); check_en = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_op1", bus.out_op1, 64'd0);
        chk("rst_op2", bus.out_op2, 64'd0);
        chk("rst_rd", 64'(bus.out_rd), 64'd0);
        reset_n = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rel_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

        send(32'h402081B3, 64'h0, 64'd10, 64'd3, 1'b0, 5'd0, 64'h0);
        chk("sub_insn30", 64'(bus.out_insn30), 64'd1);
        chk("sub_funct3", 64'(bus.out_funct3), 64'd0);
        chk("sub_w", 64'(bus.out_w), 64'd0);
        chk("sub_op1", bus.out_op1, 64'd10);
        chk("sub_op2", bus.out_op2, 64'd3);
        chk("sub_rd", 64'(bus.out_rd), 64'd3);

        send(32'h4043529B, 64'h0, 64'h1234, 64'h0, 1'b0, 5'd0, 64'h0);
        chk("sraiw_insn30", 64'(bus.out_insn30), 64'd1);
        chk("sraiw_funct3", 64'(bus.out_funct3), 64'd5);
        chk("sraiw_w", 64'(bus.out_w), 64'd1);
        chk("sraiw_shamt", 64'(bus.out_op2[4:0]), 64'd4);

        send(32'h80000097, 64'h1000, 64'h77, 64'h0, 1'b0, 5'd0, 64'h0);
        chk("auipc_op1", bus.out_op1, 64'h1000);
        chk("auipc_op2", bus.out_op2, 64'hFFFFFFFF80000000);

        send(32'h12345137, 64'h2000, 64'h77, 64'h0, 1'b0, 5'd0, 64'h0);
        chk("lui_op1", bus.out_op1, 64'd0);
        chk("lui_op2", bus.out_op2, 64'h12345000);

        send(32'h00138213, 64'h0, 64'd5, 64'd0, 1'b1, 5'd7, 64'd99);
        chk("byp_op1", bus.out_op1, 64'd99);
        chk("byp_op2", bus.out_op2, 64'd1);
        send(32'h00100213, 64'h0, 64'd5, 64'd0, 1'b1, 5'd0, 64'd99);
        chk("byp_x0_op1", bus.out_op1, 64'd5);

        send(32'h0000007F, 64'h3000, 64'h55, 64'h66, 1'b0, 5'd0, 64'h0);
        chk("ill_flag", 64'(bus.out_illegal), 64'd1);
        chk("ill_op1", bus.out_op1, 64'd0);
        chk("ill_op2", bus.out_op2, 64'd0);
        @(negedge clk);

        // Back-pressure: four in a row, out_ready low for three edges.
        bus.out_ready = 1'b0;
        drive(addi_rd(1), 64'h0, 64'h1, 64'h0, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        drive(addi_rd(2), 64'h0, 64'h2, 64'h0, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_head_a", 64'(bus.out_rd), 64'd1);
        drive(addi_rd(3), 64'h0, 64'h3, 64'h0, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        chk("bp_hold_a", 64'(bus.out_rd), 64'd1);
        chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_b", 64'(bus.out_rd), 64'd2);
        @(negedge clk);
        chk("bp_c_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_c", 64'(bus.out_rd), 64'd3);
        drive(addi_rd(4), 64'h0, 64'h4, 64'h0, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        chk("bp_d_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_d", 64'(bus.out_rd), 64'd4);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Flush with both entries full and an input offered.
        bus.out_ready = 1'b0;
        drive(addi_rd(10), 64'h0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        drive(addi_rd(11), 64'h0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0);
        @(negedge clk);
        drive(addi_rd(12), 64'h0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_dropped", 64'(bus.out_valid), 64'd0);
        drive(addi_rd(13), 64'h0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_empty_drop", 64'(bus.out_valid), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            case ($urandom_range(0, 6))
                0: r[6:0] = 7'b0110011;
                1: r[6:0] = 7'b0010011;
                2: r[6:0] = 7'b0111011;
                3: r[6:0] = 7'b0011011;
                4: r[6:0] = 7'b0110111;
                5: r[6:0] = 7'b0010111;
                default: ;
            endcase
            if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'd0;
            r[19:15] = 5'($urandom_range(0, 7));
            r[24:20] = 5'($urandom_range(0, 7));
            drive(r, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 49) == 0);
            reset_n       = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        reset_n = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("outputs_seen", 64'(n_out > 100), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
